cache_victim_writeback: RTL and testbench



---
 rtl/cache_victim_writeback_pkg.sv | 24 ++
 rtl/cache_victim_writeback_if.sv | 46 ++++
 rtl/cache_victim_writeback_onehot_check.sv | 27 ++
 rtl/cache_victim_writeback.sv | 158 +++++++++++++++
 tb/tb_cache_victim_writeback.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_victim_writeback_pkg.sv
// Shared definitions for the victim writeback block: default geometry,
// derived beat/offset widths and the eviction FSM state encoding.
package cache_victim_writeback_pkg;

  localparam int unsigned NUMWAYS_DEF = 4;
  localparam int unsigned SETLEN_DEF  = 7;
  localparam int unsigned TAGLEN_DEF  = 20;
  localparam int unsigned LINELEN_DEF = 256;
  localparam int unsigned BEATLEN_DEF = 64;

  localparam int unsigned OFFSETLEN  = $clog2(LINELEN_DEF / 8);
  localparam int unsigned BEATS      = LINELEN_DEF / BEATLEN_DEF;
  localparam int unsigned BEATIDXLEN = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    CAPTURE  = 3'd2,
    WB       = 3'd3,
    DONE     = 3'd4,
    DONE_ERR = 3'd5
  } evict_state_e;

endpackage

// File: rtl/cache_victim_writeback_if.sv
// Request, data-array read, writeback bus and invalidate signals of the
// victim writeback block. slave = the block, master = controller/arrays/bus.
interface cache_victim_writeback_if
  import cache_victim_writeback_pkg::*;
#(
  parameter int unsigned NUMWAYS = NUMWAYS_DEF,
  parameter int unsigned SETLEN  = SETLEN_DEF,
  parameter int unsigned TAGLEN  = TAGLEN_DEF,
  parameter int unsigned LINELEN = LINELEN_DEF,
  parameter int unsigned BEATLEN = BEATLEN_DEF
);
  localparam int unsigned ADRLEN = TAGLEN + SETLEN + $clog2(LINELEN / 8);

  logic                      EvictReq;
  logic                      EvictReady;
  logic [SETLEN-1:0]         Set;
  logic [NUMWAYS-1:0]        VictimWay;
  logic [NUMWAYS-1:0]        DirtyWay;
  logic [NUMWAYS*TAGLEN-1:0] TagWay;
  logic                      SramRdEn;
  logic [SETLEN-1:0]         SramSet;
  logic [NUMWAYS-1:0]        SramWay;
  logic [LINELEN-1:0]        SramRdData;
  logic                      BusValid;
  logic                      BusReady;
  logic [ADRLEN-1:0]         BusAdr;
  logic [BEATLEN-1:0]        BusData;
  logic                      BusLast;
  logic [NUMWAYS-1:0]        ClearValidWay;
  logic [NUMWAYS-1:0]        ClearDirtyWay;
  logic                      EvictDone;
  logic                      EvictErr;

  modport slave (
    input  EvictReq, Set, VictimWay, DirtyWay, TagWay, SramRdData, BusReady,
    output EvictReady, SramRdEn, SramSet, SramWay, BusValid, BusAdr, BusData,
           BusLast, ClearValidWay, ClearDirtyWay, EvictDone, EvictErr
  );

  modport master (
    output EvictReq, Set, VictimWay, DirtyWay, TagWay, SramRdData, BusReady,
    input  EvictReady, SramRdEn, SramSet, SramWay, BusValid, BusAdr, BusData,
           BusLast, ClearValidWay, ClearDirtyWay, EvictDone, EvictErr
  );

endinterface

// File: rtl/cache_victim_writeback_onehot_check.sv
// One-hot validity check of a way vector plus its binary index (index is
// only meaningful when one_hot is set).
module cache_victim_writeback_onehot_check #(
  parameter int unsigned NUMWAYS = 4
) (
  input  logic [NUMWAYS-1:0]         way,
  output logic                       one_hot,
  output logic [$clog2(NUMWAYS)-1:0] idx
);
  localparam int unsigned IDXLEN = $clog2(NUMWAYS);
  localparam int unsigned CNTLEN = $clog2(NUMWAYS + 1);

  logic [CNTLEN-1:0] cnt;

  always_comb begin
    cnt = '0;
    idx = '0;
    for (int i = 0; i < int'(NUMWAYS); i++) begin
      if (way[i]) begin
        cnt = cnt + CNTLEN'(1);
        idx = idx | IDXLEN'(i);
      end
    end
    one_hot = (cnt == CNTLEN'(1));
  end

endmodule

// File: rtl/cache_victim_writeback.sv
// Evicts the victim way chosen by the replacement policy: clean lines are
// just invalidated, dirty lines are read out and written back beat by beat.
module cache_victim_writeback
  import cache_victim_writeback_pkg::*;
#(
  parameter int unsigned NUMWAYS = NUMWAYS_DEF,
  parameter int unsigned SETLEN  = SETLEN_DEF,
  parameter int unsigned TAGLEN  = TAGLEN_DEF,
  parameter int unsigned LINELEN = LINELEN_DEF,
  parameter int unsigned BEATLEN = BEATLEN_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  cache_victim_writeback_if.slave  cif
);
  localparam int unsigned IDXLEN  = $clog2(NUMWAYS);
  localparam int unsigned N_BEATS = LINELEN / BEATLEN;
  localparam int unsigned BEAT_W  = $clog2(N_BEATS);
  localparam int unsigned BYTE_W  = $clog2(BEATLEN / 8);
  localparam int unsigned ADRLEN  = TAGLEN + SETLEN + BEAT_W + BYTE_W;

  evict_state_e         state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [SETLEN-1:0]    set_q, set_d;
  logic [NUMWAYS-1:0]   way_q, way_d;
  logic [TAGLEN-1:0]    tag_q, tag_d;
  logic [LINELEN-1:0]   line_q, line_d;

  logic                 ready_q, ready_d;
  logic                 rd_en_q, rd_en_d;
  logic [SETLEN-1:0]    sram_set_q, sram_set_d;
  logic [NUMWAYS-1:0]   sram_way_q, sram_way_d;
  logic                 valid_q, valid_d;
  logic [ADRLEN-1:0]    adr_q, adr_d;
  logic [BEATLEN-1:0]   data_q, data_d;
  logic                 last_q, last_d;
  logic [NUMWAYS-1:0]   clr_q, clr_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 victim_one_hot;
  logic [IDXLEN-1:0]    victim_idx;
  logic [TAGLEN-1:0]    tag_sel;

  cache_victim_writeback_onehot_check #(.NUMWAYS(NUMWAYS)) u_onehot (
    .way     (cif.VictimWay),
    .one_hot (victim_one_hot),
    .idx     (victim_idx)
  );

  assign tag_sel = cif.TagWay[32'(victim_idx) * TAGLEN +: TAGLEN];

  // Next state; outputs are computed from the next state so they leave flops.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    set_d   = set_q;
    way_d   = way_q;
    tag_d   = tag_q;
    line_d  = line_q;

    case (state_q)
      IDLE: begin
        if (cif.EvictReq && ready_q) begin
          set_d = cif.Set;
          way_d = cif.VictimWay;
          tag_d = tag_sel;
          if (!victim_one_hot)                        state_d = DONE_ERR;
          else if ((cif.DirtyWay & cif.VictimWay) != '0) state_d = READ;
          else                                        state_d = DONE;
        end
      end
      READ:    state_d = CAPTURE;
      CAPTURE: begin
        line_d  = cif.SramRdData;
        beat_d  = '0;
        state_d = WB;
      end
      WB: begin
        if (valid_q && cif.BusReady) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(N_BEATS - 1)) state_d = DONE;
        end
      end
      DONE, DONE_ERR: state_d = IDLE;
      default:        state_d = IDLE;
    endcase

    ready_d    = (state_d == IDLE);
    rd_en_d    = (state_d == READ);
    sram_set_d = rd_en_d ? set_d : '0;
    sram_way_d = rd_en_d ? way_d : '0;
    valid_d    = (state_d == WB);
    adr_d      = valid_d ? {tag_d, set_d, beat_d, {BYTE_W{1'b0}}} : '0;
    data_d     = valid_d ? line_d[32'(beat_d) * BEATLEN +: BEATLEN] : '0;
    last_d     = valid_d && (beat_d == BEAT_W'(N_BEATS - 1));
    clr_d      = (state_d == DONE) ? way_d : '0;
    done_d     = (state_d == DONE) || (state_d == DONE_ERR);
    err_d      = (state_d == DONE_ERR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      set_q      <= '0;
      way_q      <= '0;
      tag_q      <= '0;
      ready_q    <= 1'b1;
      rd_en_q    <= 1'b0;
      sram_set_q <= '0;
      sram_way_q <= '0;
      valid_q    <= 1'b0;
      adr_q      <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      clr_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      set_q      <= set_d;
      way_q      <= way_d;
      tag_q      <= tag_d;
      ready_q    <= ready_d;
      rd_en_q    <= rd_en_d;
      sram_set_q <= sram_set_d;
      sram_way_q <= sram_way_d;
      valid_q    <= valid_d;
      adr_q      <= adr_d;
      data_q     <= data_d;
      last_q     <= last_d;
      clr_q      <= clr_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Line buffer contents are don't-care until loaded, so no reset.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  assign cif.EvictReady    = ready_q;
  assign cif.SramRdEn      = rd_en_q;
  assign cif.SramSet       = sram_set_q;
  assign cif.SramWay       = sram_way_q;
  assign cif.BusValid      = valid_q;
  assign cif.BusAdr        = adr_q;
  assign cif.BusData       = data_q;
  assign cif.BusLast       = last_q;
  assign cif.ClearValidWay = clr_q;
  assign cif.ClearDirtyWay = clr_q;
  assign cif.EvictDone     = done_q;
  assign cif.EvictErr      = err_q;

endmodule

// File: tb/tb_cache_victim_writeback.sv
// Directed bench for cache_victim_writeback: transaction-level model checked
// every cycle, plus literal latency/address/data expectations per scenario.
module tb_cache_victim_writeback;
  import cache_victim_writeback_pkg::*;

  localparam int unsigned NW = NUMWAYS_DEF;
  localparam int unsigned SL = SETLEN_DEF;
  localparam int unsigned TL = TAGLEN_DEF;
  localparam int unsigned LL = LINELEN_DEF;
  localparam int unsigned BL = BEATLEN_DEF;
  localparam int unsigned AL = TL + SL + OFFSETLEN;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_victim_writeback_if cif();

  cache_victim_writeback dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cif     (cif)
  );

  logic [TL-1:0] tags [NW] = '{20'h11111, 20'hABCDE, 20'h22222, 20'h33333};

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk_i(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [BL-1:0] beat_word(int s, int w, int b);
    return {16'hDA7A, 16'(b), 8'(s), 8'(w), 16'hBEEF};
  endfunction

  function automatic int way_index(logic [NW-1:0] v);
    int r = 0;
    for (int i = 0; i < int'(NW); i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [LL-1:0] line_of(int s, int w);
    logic [LL-1:0] l;
    for (int b = 0; b < int'(BEATS); b++) l[b*BL +: BL] = beat_word(s, w, b);
    return l;
  endfunction

  // Data array: returns the addressed line the cycle after the read strobe.
  logic [LL-1:0] sram_q;
  always @(posedge clk) if (cif.SramRdEn) sram_q <= line_of(int'(cif.SramSet), way_index(cif.SramWay));
  assign cif.SramRdData = sram_q;

  // Event logs for the directed literal checks.
  int              done_cyc[$];
  logic [NW-1:0]   done_clr[$];
  logic            done_err[$];
  int              beat_cyc[$];
  logic [AL-1:0]   beat_adr[$];
  logic [BL-1:0]   beat_dat[$];
  logic            beat_last[$];
  int              rd_cyc[$];
  int              stall_cnt;

  always @(negedge clk) begin
    if (reset_n) begin
      if (cif.EvictDone) begin
        done_cyc.push_back(cyc); done_clr.push_back(cif.ClearValidWay); done_err.push_back(cif.EvictErr);
      end
      if (cif.BusValid && cif.BusReady) begin
        beat_cyc.push_back(cyc); beat_adr.push_back(cif.BusAdr);
        beat_dat.push_back(cif.BusData); beat_last.push_back(cif.BusLast);
      end
      if (cif.BusValid && !cif.BusReady) stall_cnt++;
      if (cif.SramRdEn) rd_cyc.push_back(cyc);
    end
  end

  task automatic clear_logs();
    done_cyc.delete(); done_clr.delete(); done_err.delete();
    beat_cyc.delete(); beat_adr.delete(); beat_dat.delete(); beat_last.delete();
    rd_cyc.delete(); stall_cnt = 0;
  endtask

  // Model: one outstanding eviction, described by kind, cycles since accept
  // (t) and beats already accepted by the bus (nb).
  bit            m_busy = 0;
  int            m_kind;  // 0 clean, 1 dirty, 2 error
  int            m_t, m_nb;
  logic [SL-1:0] m_set;
  logic [NW-1:0] m_way;
  logic [TL-1:0] m_tag;
  bit            p_stall = 0;
  logic [AL-1:0] p_adr;
  logic [BL-1:0] p_dat;
  logic          p_last;

  always @(negedge clk) begin
    bit e_ready, e_rd, e_valid, e_done, e_err;
    logic [NW-1:0] e_clr;
    if (!reset_n) begin
      chk("rst_ready", 256'(cif.EvictReady), 256'(1));
      chk("rst_valid", 256'(cif.BusValid), 256'(0));
      chk("rst_rd_en", 256'(cif.SramRdEn), 256'(0));
      chk("rst_done", 256'(cif.EvictDone), 256'(0));
      m_busy = 0;
      p_stall = 0;
    end else begin
      e_ready = !m_busy; e_rd = 0; e_valid = 0; e_done = 0; e_err = 0; e_clr = '0;
      if (m_busy) begin
        if (m_kind == 0) begin e_done = 1; e_clr = m_way; end
        else if (m_kind == 2) begin e_done = 1; e_err = 1; end
        else if (m_t == 1) e_rd = 1;
        else if (m_t >= 3 && m_nb < int'(BEATS)) e_valid = 1;
        else if (m_nb == int'(BEATS)) begin e_done = 1; e_clr = m_way; end
      end
      chk("ready", 256'(cif.EvictReady), 256'(e_ready));
      chk("sram_rd_en", 256'(cif.SramRdEn), 256'(e_rd));
      if (e_rd) begin
        chk("sram_set", 256'(cif.SramSet), 256'(m_set));
        chk("sram_way", 256'(cif.SramWay), 256'(m_way));
      end
      chk("bus_valid", 256'(cif.BusValid), 256'(e_valid));
      if (e_valid) begin
        chk("bus_adr", 256'(cif.BusAdr),
            256'({m_tag, m_set, BEATIDXLEN'(m_nb), {(OFFSETLEN-BEATIDXLEN){1'b0}}}));
        chk("bus_data", 256'(cif.BusData), 256'(beat_word(int'(m_set), way_index(m_way), m_nb)));
        chk("bus_last", 256'(cif.BusLast), 256'(m_nb == int'(BEATS) - 1));
      end
      chk("evict_done", 256'(cif.EvictDone), 256'(e_done));
      chk("evict_err", 256'(cif.EvictErr), 256'(e_err));
      chk("clear_valid", 256'(cif.ClearValidWay), 256'(e_clr));
      chk("clear_dirty", 256'(cif.ClearDirtyWay), 256'(e_clr));
      if (p_stall) begin
        chk("hold_valid", 256'(cif.BusValid), 256'(1));
        chk("hold_adr", 256'(cif.BusAdr), 256'(p_adr));
        chk("hold_data", 256'(cif.BusData), 256'(p_dat));
        chk("hold_last", 256'(cif.BusLast), 256'(p_last));
      end
      p_stall = cif.BusValid && !cif.BusReady;
      p_adr = cif.BusAdr; p_dat = cif.BusData; p_last = cif.BusLast;

      if (m_busy) begin
        if (e_valid && cif.BusReady) m_nb++;
        if (e_done) m_busy = 0;
        m_t++;
      end else if (cif.EvictReq) begin
        m_busy = 1; m_t = 1; m_nb = 0;
        m_set = cif.Set; m_way = cif.VictimWay;
        m_tag = tags[way_index(cif.VictimWay)];
        if ($countones(cif.VictimWay) != 1) m_kind = 2;
        else if ((cif.VictimWay & cif.DirtyWay) != '0) m_kind = 1;
        else m_kind = 0;
      end
    end
  end

  task automatic drive_req(input logic [SL-1:0] s, input logic [NW-1:0] v,
                           input logic [NW-1:0] d, output int acc);
    bit r;
    cif.EvictReq = 1'b1; cif.Set = s; cif.VictimWay = v; cif.DirtyWay = d;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); r = cif.EvictReady;
      @(posedge clk); #1;
      if (r) begin acc = cyc; break; end
    end
    cif.EvictReq = 1'b0; cif.VictimWay = '0; cif.DirtyWay = '0;
    if (acc < 0) chk_i("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cif.EvictDone) begin dc = cyc; break; end
    end
    @(posedge clk); #1;
    if (dc < 0) chk_i("done_timeout", 0, 1);
  endtask

  task automatic check_dirty_beats(string tag, int a, int off2, int off3);
    logic [AL-1:0] adr_exp [4] = '{32'hABCDE0A0, 32'hABCDE0A8, 32'hABCDE0B0, 32'hABCDE0B8};
    logic [BL-1:0] dat_exp [4] = '{64'hDA7A_0000_0501_BEEF, 64'hDA7A_0001_0501_BEEF,
                                   64'hDA7A_0002_0501_BEEF, 64'hDA7A_0003_0501_BEEF};
    int off_exp [4];
    off_exp = '{3, 4, off2, off3};
    chk_i({tag, "_nbeats"}, beat_cyc.size(), 4);
    chk_i({tag, "_nread"}, rd_cyc.size(), 1);
    if (rd_cyc.size() > 0) chk_i({tag, "_read_lat"}, rd_cyc[0] - a + 1, 1);
    for (int i = 0; i < 4 && i < beat_cyc.size(); i++) begin
      chk({tag, "_adr"}, 256'(beat_adr[i]), 256'(adr_exp[i]));
      chk({tag, "_data"}, 256'(beat_dat[i]), 256'(dat_exp[i]));
      chk({tag, "_last"}, 256'(beat_last[i]), 256'(i == 3));
      chk_i({tag, "_beat_lat"}, beat_cyc[i] - a + 1, off_exp[i]);
    end
  endtask

  initial begin
    int a, a2, d, d2;
    cif.EvictReq = 1'b0; cif.Set = '0; cif.VictimWay = '0; cif.DirtyWay = '0; cif.BusReady = 1'b1;
    for (int i = 0; i < int'(NW); i++) cif.TagWay[i*TL +: TL] = tags[i];
    clear_logs();

    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready", 256'(cif.EvictReady), 256'(1));
    chk("reset_clear", 256'(cif.ClearValidWay), 256'(0));

    // Clean victim
    clear_logs();
    drive_req(7'h12, 4'b0100, 4'b0011, a);
    wait_done(d);
    chk_i("clean_lat", d - a + 1, 1);
    chk_i("clean_ndone", done_cyc.size(), 1);
    if (done_cyc.size() > 0) begin
      chk("clean_clr", 256'(done_clr[0]), 256'(4'b0100));
      chk("clean_err", 256'(done_err[0]), 256'(0));
    end
    chk_i("clean_nbeats", beat_cyc.size(), 0);
    chk_i("clean_nread", rd_cyc.size(), 0);

    // Dirty victim, bus always ready
    clear_logs();
    drive_req(7'h05, 4'b0010, 4'b0010, a);
    wait_done(d);
    chk_i("dirty_lat", d - a + 1, 7);
    check_dirty_beats("dirty", a, 5, 6);
    if (done_cyc.size() > 0) chk("dirty_clr", 256'(done_clr[0]), 256'(4'b0010));

    // Dirty victim, bus stalls 5 cycles on beat 2
    clear_logs();
    drive_req(7'h05, 4'b0010, 4'b0010, a);
    repeat (4) @(posedge clk);
    #1 cif.BusReady = 1'b0;
    repeat (5) @(posedge clk);
    #1 cif.BusReady = 1'b1;
    wait_done(d);
    chk_i("stall_lat", d - a + 1, 12);
    chk_i("stall_cycles", stall_cnt, 5);
    check_dirty_beats("stall", a, 10, 11);

    // Non-one-hot victims
    for (int k = 0; k < 2; k++) begin
      logic [NW-1:0] bad;
      bad = (k == 0) ? 4'b0000 : 4'b1010;
      clear_logs();
      drive_req(7'h01, bad, 4'b1111, a);
      wait_done(d);
      chk_i("bad_lat", d - a + 1, 1);
      chk_i("bad_ndone", done_cyc.size(), 1);
      if (done_cyc.size() > 0) begin
        chk("bad_err", 256'(done_err[0]), 256'(1));
        chk("bad_clr", 256'(done_clr[0]), 256'(0));
      end
      chk_i("bad_nread", rd_cyc.size(), 0);
      chk_i("bad_nbeats", beat_cyc.size(), 0);
    end

    // Reset during beat 1 of a writeback
    clear_logs();
    drive_req(7'h05, 4'b0010, 4'b0010, a);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_valid", 256'(cif.BusValid), 256'(1));
    reset_n = 1'b0;
    #1;
    chk("rst_async_valid", 256'(cif.BusValid), 256'(0));
    chk("rst_async_ready", 256'(cif.EvictReady), 256'(1));
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 256'(cif.EvictReady), 256'(1));
    repeat (5) @(posedge clk);
    #1;
    chk_i("rst_no_done", done_cyc.size(), 0);
    drive_req(7'h33, 4'b1000, 4'b0000, a);
    wait_done(d);
    chk_i("post_rst_lat", d - a + 1, 1);
    if (done_cyc.size() > 0) chk("post_rst_clr", 256'(done_clr[0]), 256'(4'b1000));

    // Back-to-back: dirty then clean right after the first done
    clear_logs();
    drive_req(7'h05, 4'b0010, 4'b0010, a);
    wait_done(d);
    drive_req(7'h12, 4'b0100, 4'b0000, a2);
    chk_i("b2b_accept", a2 - d, 2);
    wait_done(d2);
    chk_i("b2b_lat", d2 - a2 + 1, 1);
    chk_i("b2b_ndone", done_cyc.size(), 2);
    if (done_cyc.size() == 2) begin
      chk("b2b_clr0", 256'(done_clr[0]), 256'(4'b0010));
      chk("b2b_clr1", 256'(done_clr[1]), 256'(4'b0100));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
